// File: rtl/token_pos_embedding.sv
// token_pos_embedding
//
// Token embedding stage at the front of the transformer datapath. Each
// accepted token ID selects a row from a writable token table. The row for
// the token's sequence position is added to it with per-element saturation,
// and the result is presented on a registered valid/ready output.
//
// Build option: define POS_EMBED_EN to include the positional table, its
// write path and the saturating adder. Without it, out_vec is the raw token
// row. The position counter and out_pos behave the same in both builds.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   input handshake carrying token_id and seq_start
//   token_id            token index; ids >= VOCAB are flagged out-of-vocabulary
//   seq_start           accepted token is position 0 of a new sequence
//   out_valid/out_ready output handshake carrying out_vec/out_pos/out_oov
//   out_vec             DIM signed elements, element i at [i*WIDTH +: WIDTH]
//   out_pos             sequence position of the emitted token
//   out_oov             token_id was out of range; out_vec is forced to zero
//   wr_en/wr_sel        table write strobe; sel 0 = token table, 1 = position table
//   wr_addr/wr_data     row index (upper bits ignored for smaller table) and row data

module token_pos_embedding #(
  parameter int VOCAB   = 16,
  parameter int DIM     = 4,
  parameter int WIDTH   = 8,
  parameter int MAX_SEQ = 8,
  localparam int TW  = $clog2(VOCAB),
  localparam int PW  = $clog2(MAX_SEQ),
  localparam int AW  = (TW > PW) ? TW : PW,
  localparam int ROW = DIM * WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [TW-1:0]  token_id,
  input  logic           seq_start,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [ROW-1:0] out_vec,
  output logic [PW-1:0]  out_pos,
  output logic           out_oov,
  input  logic           wr_en,
  input  logic           wr_sel,
  input  logic [AW-1:0]  wr_addr,
  input  logic [ROW-1:0] wr_data
);

  logic [ROW-1:0] tok_tab [VOCAB];
  logic [PW-1:0]  pos_q;
  logic [PW-1:0]  emit_pos;
  logic           accept;
  logic           oov;
  logic [ROW-1:0] tok_row;
  logic [ROW-1:0] sum_row;
  logic [TW-1:0]  tok_waddr;
  logic           tok_wr_ok;

  // The output register is free when it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A new sequence restarts at position 0. Otherwise the running counter is used.
  assign emit_pos = seq_start ? '0 : pos_q;

  // Only non-power-of-two vocabularies can present an out-of-range id.
  assign oov     = 32'(token_id) >= VOCAB;
  assign tok_row = tok_tab[token_id];

  assign tok_waddr = wr_addr[TW-1:0];
  assign tok_wr_ok = 32'(tok_waddr) < VOCAB;

  // Token table. Lookups read the current contents combinationally, so a
  // write to the row being looked up in the same cycle is seen only by later
  // tokens. Reset clears every row and masks any write in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < VOCAB; r++) tok_tab[r] <= '0;
    end else if (wr_en && !wr_sel && tok_wr_ok) begin
      tok_tab[tok_waddr] <= wr_data;
    end
  end

`ifdef POS_EMBED_EN
  logic [ROW-1:0] pos_tab [MAX_SEQ];
  logic [ROW-1:0] pos_row;
  logic [PW-1:0]  pos_waddr;
  logic           pos_wr_ok;

  assign pos_waddr = wr_addr[PW-1:0];
  assign pos_wr_ok = 32'(pos_waddr) < MAX_SEQ;
  assign pos_row   = pos_tab[emit_pos];

  // Position table. It follows the same write and reset rules as the token table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < MAX_SEQ; r++) pos_tab[r] <= '0;
    end else if (wr_en && wr_sel && pos_wr_ok) begin
      pos_tab[pos_waddr] <= wr_data;
    end
  end

  // Per-element saturating add. Each sum is formed one bit wider. When the
  // two top bits disagree, the result left the WIDTH-bit range, and the
  // wider sign bit tells which rail to clamp to.
  always_comb begin
    sum_row = '0;
    for (int i = 0; i < DIM; i++) begin
      logic [WIDTH:0] s;
      s = {tok_row[i*WIDTH+WIDTH-1], tok_row[i*WIDTH +: WIDTH]}
        + {pos_row[i*WIDTH+WIDTH-1], pos_row[i*WIDTH +: WIDTH]};
      if (s[WIDTH] != s[WIDTH-1])
        sum_row[i*WIDTH +: WIDTH] = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
      else
        sum_row[i*WIDTH +: WIDTH] = s[WIDTH-1:0];
    end
  end
`else
  // Without positional embedding, the token row passes through unchanged.
  assign sum_row = tok_row;
`endif

  // Output register and position counter. A new token loads on accept, even
  // while the previous result is being drained. Otherwise a drain empties
  // the register. Reset drops any pending result and ignores any handshake
  // in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_pos   <= '0;
      out_oov   <= 1'b0;
      pos_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_vec   <= oov ? '0 : sum_row;
      out_pos   <= emit_pos;
      out_oov   <= oov;
      pos_q     <= (emit_pos == PW'(MAX_SEQ - 1)) ? '0 : emit_pos + PW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_token_pos_embedding.sv
// tb_token_pos_embedding
//
// Directed bench for token_pos_embedding with default parameters. Expected
// vectors are hand-computed for both builds. The value for the positional
// build is used when POS_EMBED_EN is defined, and the raw token row otherwise.

module tb_token_pos_embedding;

  localparam int VOCAB   = 16;
  localparam int DIM     = 4;
  localparam int WIDTH   = 8;
  localparam int MAX_SEQ = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  token_id;
  logic        seq_start;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_vec;
  logic [2:0]  out_pos;
  logic        out_oov;
  logic        wr_en;
  logic        wr_sel;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  int pass_count  = 0;
  int check_count = 0;

  token_pos_embedding #(
    .VOCAB(VOCAB), .DIM(DIM), .WIDTH(WIDTH), .MAX_SEQ(MAX_SEQ)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .token_id(token_id), .seq_start(seq_start),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_pos(out_pos), .out_oov(out_oov),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tok;
    logic        start;
    logic [31:0] vec_pos;
    logic [31:0] vec_raw;
    logic [2:0]  pos;
  } vector_t;

  vector_t vectors [7];

  // Pick the expected vector for whichever build is being simulated
  function automatic logic [31:0] pick(input logic [31:0] with_pos, input logic [31:0] raw);
`ifdef POS_EMBED_EN
    return with_pos;
`else
    return raw;
`endif
  endfunction

  // Compare one observed value against its expected value and keep the tally
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Advance to just after the next rising edge, where inputs are driven and outputs sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one table row
  task automatic writeRow(input logic sel, input logic [3:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Offer one token for a single cycle (callers ensure in_ready is high)
  task automatic applyStimulus(input logic [3:0] tok, input logic start);
    in_valid = 1'b1; token_id = tok; seq_start = start;
    tick();
    in_valid = 1'b0; seq_start = 1'b0;
  endtask

  // Main sequence: reset, table loads, vector table, then multi-cycle corner cases
  initial begin
    rst = 1'b1; in_valid = 1'b0; token_id = '0; seq_start = 1'b0;
    out_ready = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;

    vectors[0] = '{4'd1, 1'b1, 32'h0403020B, 32'h04030201, 3'd0};
    vectors[1] = '{4'd2, 1'b0, 32'h7F7F8080, 32'h7F7F8080, 3'd1};
    vectors[2] = '{4'd3, 1'b0, 32'h11F17F82, 32'h10F07F81, 3'd2};
    vectors[3] = '{4'd4, 1'b0, 32'h0080FF01, 32'h01FF7F01, 3'd3};
    vectors[4] = '{4'd0, 1'b0, 32'h00000000, 32'h00000000, 3'd4};
    vectors[5] = '{4'd1, 1'b1, 32'h0403020B, 32'h04030201, 3'd0};
    vectors[6] = '{4'd1, 1'b0, 32'h0908F2F1, 32'h04030201, 3'd1};

    // Reset held two cycles
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_vec",   64'(out_vec),   64'd0);
    checkOutput("reset out_pos",   64'(out_pos),   64'd0);
    checkOutput("reset out_oov",   64'(out_oov),   64'd0);
    checkOutput("reset in_ready",  64'(in_ready),  64'd1);

    applyStimulus(4'd5, 1'b1);
    checkOutput("empty out_valid", 64'(out_valid), 64'd1);
    checkOutput("empty out_vec",   64'(out_vec),   64'd0);
    checkOutput("empty out_pos",   64'(out_pos),   64'd0);

    writeRow(1'b0, 4'd1, 32'h04030201);
    writeRow(1'b1, 4'd0, 32'h0000000A);
    writeRow(1'b0, 4'd2, 32'h7F7F8080);
    writeRow(1'b1, 4'd1, 32'h0505F0F0);
    writeRow(1'b0, 4'd3, 32'h10F07F81);
    writeRow(1'b1, 4'd2, 32'h01010101);
    writeRow(1'b0, 4'd4, 32'h01FF7F01);
    writeRow(1'b1, 4'd3, 32'hFF808000);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vectors[i].tok, vectors[i].start);
      checkOutput($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("vec%0d out_vec", i), 64'(out_vec),
                  64'(pick(vectors[i].vec_pos, vectors[i].vec_raw)));
      checkOutput($sformatf("vec%0d out_pos", i), 64'(out_pos), 64'(vectors[i].pos));
      checkOutput($sformatf("vec%0d out_oov", i), 64'(out_oov), 64'd0);
    end

    // Lookup and write of the same row in one cycle returns the old row
    in_valid = 1'b1; token_id = 4'd1; seq_start = 1'b1;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd1; wr_data = 32'h01010101;
    tick();
    in_valid = 1'b0; seq_start = 1'b0; wr_en = 1'b0;
    checkOutput("rbw old row", 64'(out_vec), 64'(pick(32'h0403020B, 32'h04030201)));
    applyStimulus(4'd1, 1'b1);
    checkOutput("rbw new row", 64'(out_vec), 64'(pick(32'h0101010B, 32'h01010101)));

    // Backpressure: result held for three stalled cycles, no loss or duplication
    writeRow(1'b0, 4'd5, 32'h05050505);
    writeRow(1'b0, 4'd6, 32'h06060606);
    writeRow(1'b0, 4'd7, 32'h07070707);
    in_valid = 1'b1; token_id = 4'd5; seq_start = 1'b1;
    tick();
    out_ready = 1'b0; token_id = 4'd6; seq_start = 1'b0;
    #1;
    checkOutput("stall in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("stall%0d in_ready", c), 64'(in_ready), 64'd0);
      checkOutput($sformatf("stall%0d out_valid", c), 64'(out_valid), 64'd1);
      checkOutput($sformatf("stall%0d out_vec", c), 64'(out_vec), 64'(pick(32'h0505050F, 32'h05050505)));
      checkOutput($sformatf("stall%0d out_pos", c), 64'(out_pos), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("bp tok6 out_vec", 64'(out_vec), 64'(pick(32'h0B0BF6F6, 32'h06060606)));
    checkOutput("bp tok6 out_pos", 64'(out_pos), 64'd1);
    token_id = 4'd7;
    tick();
    checkOutput("bp tok7 out_vec", 64'(out_vec), 64'(pick(32'h08080808, 32'h07070707)));
    checkOutput("bp tok7 out_pos", 64'(out_pos), 64'd2);
    in_valid = 1'b0;
    tick();
    checkOutput("bp drained", 64'(out_valid), 64'd0);

    // Wrap: nine back-to-back tokens, seq_start only on the first
    in_valid = 1'b1; token_id = 4'd0; seq_start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      seq_start = 1'b0;
      checkOutput($sformatf("wrap%0d out_valid", k), 64'(out_valid), 64'd1);
      checkOutput($sformatf("wrap%0d out_pos", k), 64'(out_pos), 64'(k % MAX_SEQ));
    end
    // Next run continues 1,2,3; seq_start on its fourth token restarts at 0
    for (int k = 0; k < 4; k++) begin
      seq_start = (k == 3);
      tick();
      checkOutput($sformatf("restart%0d out_pos", k), 64'(out_pos), 64'((k == 3) ? 0 : k + 1));
    end
    in_valid = 1'b0; seq_start = 1'b0;
    tick();

    // Reset mid-stream: pending output dropped, handshake and write ignored
    out_ready = 1'b0;
    applyStimulus(4'd2, 1'b1);
    checkOutput("pending out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; in_valid = 1'b1; token_id = 4'd1;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd1; wr_data = 32'hFFFFFFFF;
    tick();
    rst = 1'b0; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
    checkOutput("rst out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst in_ready",  64'(in_ready),  64'd1);
    applyStimulus(4'd1, 1'b0);
    checkOutput("post-rst out_vec", 64'(out_vec), 64'd0);
    checkOutput("post-rst out_pos", 64'(out_pos), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/token_pos_embedding.md
# token_pos_embedding

Parametrised token embedding stage with optional learned positional embedding, placed at the front of the transformer datapath between the tokenizer stream and the first attention block. It accepts one token ID per valid/ready handshake, looks up a DIM-element signed vector from a writable token table, adds the row for the current sequence position with saturation, and presents the result on a registered valid/ready output. Both tables are loaded at runtime through a single write port.

## Interface
Parameters:
- VOCAB, 16: number of token table rows.
- DIM, 4: elements per embedding vector.
- WIDTH, 8: bits per element, two's-complement signed.
- MAX_SEQ, 8: number of positional table rows; position counter modulus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  token_id/seq_start valid.
- in_ready  out  1  block can accept a token this cycle.
- token_id  in  $clog2(VOCAB)  token index.
- seq_start  in  1  accepted token is position 0 of a new sequence.
- out_valid  out  1  out_vec/out_pos/out_oov valid.
- out_ready  in  1  downstream accepts output.
- out_vec  out  DIM*WIDTH  element i at [i*WIDTH +: WIDTH].
- out_pos  out  $clog2(MAX_SEQ)  position of the emitted token.
- out_oov  out  1  token_id >= VOCAB; out_vec forced to 0.
- wr_en  in  1  table write strobe.
- wr_sel  in  1  0 = token table, 1 = position table.
- wr_addr  in  max($clog2(VOCAB),$clog2(MAX_SEQ))  row index; upper bits ignored for the smaller table; out-of-range address ignored.
- wr_data  in  DIM*WIDTH  row data, same packing as out_vec.

## Operation
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready (combinational from out_valid/out_ready).
- Position counter pos_q: on accept, emitted position = seq_start ? 0 : pos_q; pos_q <= emitted+1, wrapping MAX_SEQ-1 -> 0.
- Element i result = sat(tok[token_id][i] + pos[emitted][i]); sum formed at WIDTH+1 bits; >2^(WIDTH-1)-1 clamps to max, < -2^(WIDTH-1) clamps to min.
- token_id >= VOCAB (non-power-of-two VOCAB only): out_vec = 0, out_oov = 1; position still consumed.
- Output register loads on accept; holds stable while out_valid && !out_ready.
- Writes: any cycle, independent of handshake. Write and lookup of same row in same cycle: lookup returns old row (read-before-write).
- Both tables are flip-flop arrays, cleared to 0 by rst.

## Timing
- Latency: 1 cycle accept -> out_valid.
- Throughput: 1 token/cycle with out_ready held high.
- Reset values: out_valid 0, out_vec 0, out_pos 0, out_oov 0, pos_q 0, all table rows 0; in_ready 1 in the first cycle after rst deasserts.
- rst mid-stream: pending output dropped; in-flight handshake ignored; writes in the rst cycle ignored.
- Simultaneous output drain and new accept: new data loads, out_valid stays 1.
- seq_start is sampled only on accept; ignored otherwise.

## Configuration
- POS_EMBED_EN defined: positional table, its write path and the saturating adder are present; behaviour as above.
- Not defined: out_vec = tok[token_id] unmodified; position table absent; wr_sel=1 writes ignored; pos_q and out_pos still count as specified.

## Test plan
Defaults VOCAB=16, DIM=4, WIDTH=8, MAX_SEQ=8, POS_EMBED_EN defined.
- Reset: hold rst 2 cycles -> all outputs 0, in_ready 1; token 5 sent -> out_vec 0x00000000, out_pos 0.
- Basic add: write tok[1]=0x04030201, pos[0]=0x0000000A; send token 1 with seq_start -> next cycle out_valid, out_vec 0x0403020B, out_pos 0.
- Saturation: tok[2]=0x7F7F8080, pos[1]=0x0505F0F0; send token 2 at position 1 -> out_vec 0x7F7F8080.
- Backpressure: out_ready low 3 cycles with in_valid high -> in_ready 0, out_vec stable; release -> no token lost or duplicated, order preserved.
- Wrap and restart: 9 back-to-back tokens, seq_start only on first -> out_pos 0..7,0; seq_start on token 4 of next run -> out_pos 0.
- Macro off: rebuild without POS_EMBED_EN; same stimulus as basic add -> out_vec 0x04030201.
